// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-addressed RAM responder with fetch/data read ports, byte-enabled store and clear sequencer
// Optional feature: define RAM_RANGE_CHECK_EN for out-of-range detection (sticky o_fault, suppressed writes, zeroed reads).
module ram_responder #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
  output logic [DATA_WIDTH:0]   o_read_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_busy,
  output logic                  o_fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH:0]   r_mem [0:DEPTH-1];
  logic [DATA_WIDTH:0]   r_fetch_data, r_read_data;
  logic                  r_fault;

  logic [DEPTH_LOG2-1:0] w_fetch_idx, w_read_idx, w_write_idx;
  logic                  w_fetch_oor, w_read_oor, w_write_oor;
  logic                  w_ready, w_clear_we, w_wr_act;
  logic                  w_fetch_zero, w_read_zero, w_fault_set;
  logic [DATA_WIDTH:0]   w_mask;
  logic [DATA_WIDTH:0]   w_fetch_raw, w_read_raw, w_fetch_fwd, w_read_fwd;

  assign w_fetch_idx = i_read_fetch_addr[DEPTH_LOG2-1:0];
  assign w_read_idx  = i_read_addr[DEPTH_LOG2-1:0];
  assign w_write_idx = i_write_addr[DEPTH_LOG2-1:0];
  assign w_fetch_oor = |i_read_fetch_addr[ADDR_WIDTH:DEPTH_LOG2];
  assign w_read_oor  = |i_read_addr[ADDR_WIDTH:DEPTH_LOG2];
  assign w_write_oor = |i_write_addr[ADDR_WIDTH:DEPTH_LOG2];

  assign w_ready    = (r_state == S_READY);
  assign w_clear_we = ~rst & clk_en & (r_state == S_CLEAR);
  assign w_mask     = {{8{i_byte_enable[3]}}, {8{i_byte_enable[2]}},
                       {8{i_byte_enable[1]}}, {8{i_byte_enable[0]}}};

`ifdef RAM_RANGE_CHECK_EN
  assign w_wr_act     = ~rst & clk_en & w_ready & i_write_enable & ~w_write_oor;
  assign w_fetch_zero = w_fetch_oor;
  assign w_read_zero  = w_read_oor;
  assign w_fault_set  = clk_en & w_ready &
                        (w_fetch_oor | (i_read_req & w_read_oor) |
                         (i_write_enable & (|i_byte_enable) & w_write_oor));
`else
  // Upper address bits alias; the range decode is kept only to be consumed here.
  logic w_unused_oor;
  assign w_unused_oor = w_fetch_oor ^ w_read_oor ^ w_write_oor;
  assign w_wr_act     = ~rst & clk_en & w_ready & i_write_enable;
  assign w_fetch_zero = 1'b0;
  assign w_read_zero  = 1'b0;
  assign w_fault_set  = 1'b0;
`endif

  // Write-first bypass: a read hitting the word being stored sees the merged result.
  assign w_fetch_raw = r_mem[w_fetch_idx];
  assign w_read_raw  = r_mem[w_read_idx];
  assign w_fetch_fwd = (w_wr_act && (w_fetch_idx == w_write_idx)) ?
                       ((w_fetch_raw & ~w_mask) | (i_write_data & w_mask)) : w_fetch_raw;
  assign w_read_fwd  = (w_wr_act && (w_read_idx == w_write_idx)) ?
                       ((w_read_raw & ~w_mask) | (i_write_data & w_mask)) : w_read_raw;

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear sequencing: one word per enabled cycle, READY after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clk_en && (r_state == S_CLEAR)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = S_READY;
      end
    end
  end

  // Single write port: clear zeroing or byte-lane store.
  always_ff @(posedge clk) begin
    if (w_clear_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_act) begin
      for (int k = 0; k < 4; k++) begin
        if (i_byte_enable[k]) begin
          r_mem[w_write_idx][8*k +: 8] <= i_write_data[8*k +: 8];
        end
      end
    end
  end

  // Registered read outputs; fetch every enabled cycle, data read on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_data <= '0;
      r_read_data  <= '0;
    end else if (clk_en && w_ready) begin
      r_fetch_data <= w_fetch_zero ? '0 : w_fetch_fwd;
      if (i_read_req) begin
        r_read_data <= w_read_zero ? '0 : w_read_fwd;
      end
    end
  end

  // Sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign o_read_fetch_data = r_fetch_data;
  assign o_read_data       = r_read_data;
  assign o_busy            = (r_state == S_CLEAR);
  assign o_fault           = r_fault;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder with a word-level reference model
module tb_ram_responder;

  localparam int DEPTH = 4096;
`ifdef RAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [31:0] i_read_fetch_addr = '0;
  logic [31:0] o_read_fetch_data;
  logic        i_read_req = 1'b0;
  logic [31:0] i_read_addr = '0;
  logic [31:0] o_read_data;
  logic        i_write_enable = 1'b0;
  logic [3:0]  i_byte_enable = '0;
  logic [31:0] i_write_addr = '0;
  logic [31:0] i_write_data = '0;
  logic        o_busy;
  logic        o_fault;

  int n_cmp = 0;
  int n_bad = 0;

  ram_responder dut (
    .clk               (clk),
    .rst               (rst),
    .clk_en            (clk_en),
    .i_read_fetch_addr (i_read_fetch_addr),
    .o_read_fetch_data (o_read_fetch_data),
    .i_read_req        (i_read_req),
    .i_read_addr       (i_read_addr),
    .o_read_data       (o_read_data),
    .i_write_enable    (i_write_enable),
    .i_byte_enable     (i_byte_enable),
    .i_write_addr      (i_write_addr),
    .i_write_data      (i_write_data),
    .o_busy            (o_busy),
    .o_fault           (o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words in an array, clear progress as a count of words left.
  logic [31:0] m_mem [0:DEPTH-1];
  int          m_clear_left = 0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_rd = '0;
  logic        m_fault = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    bit f_oor, r_oor, w_oor;
    if (rst) begin
      m_clear_left = DEPTH;
      m_fetch = '0;
      m_rd = '0;
      m_fault = 1'b0;
      m_valid = 1'b1;
    end else if (clk_en && m_valid) begin
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left] = '0;
        m_clear_left--;
      end else begin
        f_oor = RC && (i_read_fetch_addr >= DEPTH);
        r_oor = RC && (i_read_addr >= DEPTH);
        w_oor = RC && (i_write_addr >= DEPTH);
        if (f_oor || (i_read_req && r_oor) || (i_write_enable && i_byte_enable != 0 && w_oor))
          m_fault = 1'b1;
        if (i_write_enable && !w_oor)
          for (int k = 0; k < 4; k++)
            if (i_byte_enable[k])
              m_mem[i_write_addr % DEPTH][8*k +: 8] = i_write_data[8*k +: 8];
        m_fetch = f_oor ? 32'h0 : m_mem[i_read_fetch_addr % DEPTH];
        if (i_read_req)
          m_rd = r_oor ? 32'h0 : m_mem[i_read_addr % DEPTH];
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, o_busy}, {31'b0, (m_clear_left > 0)});
      chk("fault", {31'b0, o_fault}, {31'b0, m_fault});
      chk("fetch_data", o_read_fetch_data, m_fetch);
      chk("read_data", o_read_data, m_rd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    i_write_enable = 1'b1;
    i_write_addr = a;
    i_write_data = d;
    i_byte_enable = be;
    tick();
    i_write_enable = 1'b0;
    i_byte_enable = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    i_read_req = 1'b1;
    i_read_addr = a;
    tick();
    i_read_req = 1'b0;
    chk(nm, o_read_data, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 10000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    // Reset and full clear.
    rst = 1'b1;
    clk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_after_reset", {31'b0, o_busy}, 32'h1);
    chk("fetch_after_reset", o_read_fetch_data, 32'h0);
    count_busy(n);
    chk("busy_cycles", n, 32'd4096);
    rd(32'h0000_0FFF, 32'h0, "read_fff_cleared");

    // Full word then lanes.
    wr(32'd5, 32'hDEAD_BEEF, 4'b1111);
    rd(32'd5, 32'hDEAD_BEEF, "full_word");
    wr(32'd5, 32'h0000_00AA, 4'b0001);
    rd(32'd5, 32'hDEAD_BEAA, "byte0");
    wr(32'd5, 32'h0000_1234, 4'b0011);
    rd(32'd5, 32'hDEAD_1234, "half0");
    wr(32'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(32'd5, 32'hDEAD_1234, "be_none");

    // Same-cycle forwarding on both ports.
    i_write_enable = 1'b1;
    i_write_addr = 32'd7;
    i_write_data = 32'h1122_3344;
    i_byte_enable = 4'b1111;
    i_read_fetch_addr = 32'd7;
    i_read_req = 1'b1;
    i_read_addr = 32'd7;
    tick();
    chk("fwd_fetch", o_read_fetch_data, 32'h1122_3344);
    chk("fwd_read", o_read_data, 32'h1122_3344);
    i_read_req = 1'b0;
    i_write_data = 32'hFF00_0000;
    i_byte_enable = 4'b1000;
    tick();
    chk("fwd_fetch_lane3", o_read_fetch_data, 32'hFF22_3344);
    chk("read_hold", o_read_data, 32'h1122_3344);
    i_write_enable = 1'b0;
    i_byte_enable = '0;

    // clk_en gating.
    clk_en = 1'b0;
    i_write_enable = 1'b1;
    i_write_addr = 32'd9;
    i_write_data = 32'hCAFE_F00D;
    i_byte_enable = 4'b1111;
    i_read_req = 1'b1;
    i_read_addr = 32'd5;
    i_read_fetch_addr = 32'd5;
    tick();
    tick();
    chk("gate_fetch_hold", o_read_fetch_data, 32'hFF22_3344);
    chk("gate_read_hold", o_read_data, 32'h1122_3344);
    i_write_enable = 1'b0;
    i_byte_enable = '0;
    i_read_req = 1'b0;
    i_read_fetch_addr = 32'd0;
    clk_en = 1'b1;
    rd(32'd9, 32'h0, "gate_no_write");

    // Out-of-range write: faults with the check, aliases to word 0 without.
    wr(32'h0000_1000, 32'h0000_0055, 4'b1111);
    chk("fault_set", {31'b0, o_fault}, RC ? 32'h1 : 32'h0);
    rd(32'd0, RC ? 32'h0 : 32'h0000_0055, "oor_alias");
    chk("fault_sticky", {31'b0, o_fault}, RC ? 32'h1 : 32'h0);

    // Reset from READY, then freeze mid-clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fault_cleared", {31'b0, o_fault}, 32'h0);
    repeat (100) tick();
    clk_en = 1'b0;
    repeat (50) tick();
    chk("busy_frozen", {31'b0, o_busy}, 32'h1);
    clk_en = 1'b1;
    count_busy(n);
    chk("busy_remaining", n, 32'd3996);
    rd(32'd5, 32'h0, "recleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
